mips_cpu_mult_div: RTL

Multiply/divide unit that owns the architectural HI/LO registers. It consumes the 3-bit toMult operation code produced by ALU control, together with the rs/rt operands. MULT/MULTU/DIV/DIVU run as a 32-iteration sequential engine with a start/busy/done handshake. MTHI/MTLO/MFHI/MFLO complete in one cycle. The CPU control stalls on busy.

---
 rtl/mips_cpu_mult_pkg.sv | 24 ++
 rtl/mips_cpu_div_step.sv | 25 ++
 rtl/mips_cpu_mult_div.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_mult_pkg.sv
// rtl/mips_cpu_mult_pkg.sv - shared types and constants for the HI/LO multiply/divide unit
package mips_cpu_mult_pkg;

    typedef enum logic [2:0] {
        OP_DIVU  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_MULT  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_MFHI  = 3'b110,
        OP_MFLO  = 3'b111
    } mult_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    localparam int          MD_ITER = 32;
    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/mips_cpu_div_step.sv
// rtl/mips_cpu_div_step.sv - one combinational restoring-division step
// Shifts the next dividend bit into the partial remainder and trial-subtracts the divisor.
module mips_cpu_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] diff;
    logic             borrow;

    always_comb begin
        shifted = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
        diff    = {1'b0, shifted} - {2'b00, divisor_i};
        borrow  = diff[WIDTH+1];
        rem_o   = borrow ? shifted : diff[WIDTH:0];
        quo_o   = {quo_i[WIDTH-2:0], ~borrow};
    end

endmodule

// File: rtl/mips_cpu_mult_div.sv
// rtl/mips_cpu_mult_div.sv - HI/LO multiply/divide unit; MIPS_CPU_MULT_FAST_EN selects single-cycle multiply
// Arithmetic ops run on magnitudes through IDLE->RUN(32)->FIX; FIX restores signs and writes HI/LO.
module mips_cpu_mult_div
    import mips_cpu_mult_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int ITER  = MD_ITER
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd_data
);

`ifdef MIPS_CPU_MULT_FAST_EN
    localparam bit FAST_MUL = 1'b1;
`else
    localparam bit FAST_MUL = 1'b0;
`endif

    md_state_t          state_q, state_d;
    logic [5:0]         cnt_q, cnt_d;
    logic               is_mul_q, is_mul_d;
    logic               neg_q, neg_d;
    logic               rem_neg_q, rem_neg_d;
    logic [WIDTH-1:0]   mc_q, mc_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [WIDTH-1:0]   rd_q, rd_d;
    logic               done_q, done_d;

    mult_op_t           op_e;
    logic               op_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] fast_prod;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     step_rem;
    logic [WIDTH-1:0]   step_quo;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    mips_cpu_div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i     (rem_q),
        .quo_i     (acc_q[WIDTH-1:0]),
        .divisor_i (mc_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    always_comb begin
        op_e      = mult_op_t'(op);
        op_signed = op[1];
        a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
        b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;
        fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
        if (op_signed && (a[WIDTH-1] ^ b[WIDTH-1]))
            fast_prod = -fast_prod;
        // Shift-add: low half of acc holds the not-yet-consumed multiplier bits.
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? mc_q : {WIDTH{1'b0}})};
        quo_fix = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix = rem_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_mul_d  = is_mul_q;
        neg_d     = neg_q;
        rem_neg_d = rem_neg_q;
        mc_d      = mc_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        rd_d      = rd_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (op[2]) begin
                        done_d = 1'b1;
                        case (op_e)
                            OP_MTHI: hi_d = a;
                            OP_MTLO: lo_d = a;
                            OP_MFHI: rd_d = hi_q;
                            OP_MFLO: rd_d = lo_q;
                            default: ;
                        endcase
                    end else if (!op[0] && (b == '0)) begin
                        hi_d   = a;
                        lo_d   = DIV0_LO;
                        done_d = 1'b1;
                    end else if (FAST_MUL && op[0]) begin
                        {hi_d, lo_d} = fast_prod;
                        done_d       = 1'b1;
                    end else begin
                        is_mul_d  = op[0];
                        neg_d     = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        rem_neg_d = op_signed && a[WIDTH-1];
                        mc_d      = op[0] ? a_mag : b_mag;
                        acc_d     = {{WIDTH{1'b0}}, (op[0] ? b_mag : a_mag)};
                        rem_d     = '0;
                        cnt_d     = '0;
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                if (is_mul_q) begin
                    acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                end else begin
                    acc_d[WIDTH-1:0] = step_quo;
                    rem_d            = step_rem;
                end
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'(ITER - 1))
                    state_d = FIX;
            end
            FIX: begin
                if (is_mul_q) begin
                    {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
                end else begin
                    lo_d = quo_fix;
                    hi_d = rem_fix;
                end
                done_d  = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_mul_q  <= 1'b0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            mc_q      <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            rd_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_mul_q  <= is_mul_d;
            neg_q     <= neg_d;
            rem_neg_q <= rem_neg_d;
            mc_q      <= mc_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            rd_q      <= rd_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign rd_data = rd_q;

endmodule
